// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states
// and the op-class helpers used by both the datapath and the control FSM.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the execute stage and the multiply/divide unit.
// The core stalls on busy; done/regwrite_out drive the register-file write port.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic            flush;
    op_e             op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            regwrite_out;

    modport master (
        output start, flush, op, operand_a, operand_b, rd_in,
        input  busy, done, result, rd_out, regwrite_out
    );

    modport slave (
        input  start, flush, op, operand_a, operand_b, rd_in,
        output busy, done, result, rd_out, regwrite_out
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: one bit per cycle, 34 cycles start-to-done (2 for div special cases).
// No queueing: start is only taken in IDLE/DONE and the core must stall while busy is high.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic             neg_a, neg_b;
    logic [XLEN-1:0]  acc_hi, acc_lo, opd;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rd_q;

    logic             can_accept, div0, ovf, special, last_iter;
    logic             sa, sb;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [XLEN-1:0]  div_rem;
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]  quo_fix, rem_fix, fix_val;

    assign can_accept = (state == ST_IDLE || state == ST_DONE) && bus.start && !bus.flush;
    assign div0       = is_div(bus.op) && (bus.operand_b == '0);
    assign ovf        = (bus.op == OP_DIV || bus.op == OP_REM)
                        && (bus.operand_a == INT_MIN) && (bus.operand_b == '1);
    assign special    = div0 || ovf;
    assign last_iter  = (cnt == CNT_W'(XLEN-1));

    assign sa    = is_signed_a(bus.op) && bus.operand_a[XLEN-1];
    assign sb    = is_signed_b(bus.op) && bus.operand_b[XLEN-1];
    assign mag_a = sa ? -bus.operand_a : bus.operand_a;
    assign mag_b = sb ? -bus.operand_b : bus.operand_b;

    // Multiply: {acc_hi, acc_lo} is the product/multiplier pair shifted right each step.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
    // Divide: acc_hi is the remainder, acc_lo the dividend shifting out / quotient shifting in.
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opd});
    assign div_rem   = div_shift[XLEN-1:0] - opd;

    assign product  = {acc_hi, acc_lo};
    assign prod_fix = (neg_a ^ neg_b) ? -product : product;
    assign quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    assign rem_fix  = neg_a ? -acc_hi : acc_hi;

    always_comb begin
        fix_val = '0;
        unique case (op_q)
            OP_MUL:                       fix_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = quo_fix;
            OP_REM, OP_REMU:              fix_val = rem_fix;
            default:                      fix_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (can_accept) state_nxt = special ? ST_FIX : ST_CALC;
                else            state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                if (bus.flush)      state_nxt = ST_IDLE;
                else if (last_iter) state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = bus.flush ? ST_IDLE : ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            op_q     <= OP_MUL;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opd      <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            if (can_accept) begin
                op_q <= bus.op;
                rd_q <= bus.rd_in;
                cnt  <= '0;
                opd  <= special ? '0 : mag_b;
                if (special) begin
                    // Preload the final quotient/remainder so FIX passes them through unsigned.
                    neg_a  <= 1'b0;
                    neg_b  <= 1'b0;
                    acc_hi <= div0 ? bus.operand_a : '0;
                    acc_lo <= div0 ? '1 : INT_MIN;
                end else begin
                    neg_a  <= sa;
                    neg_b  <= sb;
                    acc_hi <= '0;
                    acc_lo <= mag_a;
                end
            end else if (state == ST_CALC && !bus.flush) begin
                cnt <= cnt + CNT_W'(1);
                if (is_div(op_q)) begin
                    acc_hi <= div_ge ? div_rem : div_shift[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
            end
            if (state == ST_FIX && !bus.flush) result_q <= fix_val;
        end
    end

    assign bus.busy         = (state == ST_CALC) || (state == ST_FIX);
    assign bus.done         = (state == ST_DONE);
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_q;
    assign bus.regwrite_out = bus.done && (rd_q != 5'd0);

endmodule
